// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 / interrupt unit: register numbers,
// exception codes, register bit positions, the FSM state type and the
// interrupt priority encoder.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  localparam int IE_BIT = 0;
  localparam int IP_LSB = 8;
  localparam int DF_BIT = 31;

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } cp0_state_e;

  // Index of the lowest set bit; lower index means higher priority.
  function automatic logic [2:0] lowest_set_idx(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/cp0_irq_sync.sv
// Multi-flop synchroniser for the asynchronous interrupt request lines.
// Each bit is an independent level; no pulse stretching is done here.
module cp0_irq_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the raw request levels through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/cp0_irq_unit.sv
// Coprocessor-0 and interrupt unit: STATUS/CAUSE/EPC registers, masked and
// prioritised interrupt lines, syscall/eret handling and the RUN/HANDLER FSM.
// Optional timer (COUNT/COMPARE) is built when CP0_TIMER_EN is defined; it
// adds one extra pending line above the external ones with lowest priority.
module cp0_irq_unit import cp0_pkg::*; #(
  parameter int              N_IRQ       = 6,
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] VEC_BASE    = 32'h0000_00D8,
  parameter int              SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             take_window,
  input  logic [XLEN-1:0]  epc_in,
  input  logic             syscall,
  input  logic             eret,
  input  logic             cp0_we,
  input  logic [4:0]       cp0_addr,
  input  logic [XLEN-1:0]  cp0_wdata,
  output logic [XLEN-1:0]  cp0_rdata,
  output logic             take,
  output logic [XLEN-1:0]  vec_pc,
  output logic [XLEN-1:0]  eret_pc,
  output logic             in_handler,
  output logic [2:0]       irq_id
);

`ifdef CP0_TIMER_EN
  localparam int NL = N_IRQ + 1;
`else
  localparam int NL = N_IRQ;
`endif

  cp0_state_e      state_q, state_d;
  logic            ie_q, ie_d;
  logic [NL-1:0]   im_q, im_d;
  logic [NL-1:0]   ip_q, ip_d;
  logic [4:0]      exc_q, exc_d;
  logic            df_q, df_d;
  logic [XLEN-1:0] epc_q, epc_d;

  logic [N_IRQ-1:0] irq_sync_s;
  logic [NL-1:0]    ip_set_s;
  logic [NL-1:0]    ip_clr_s;
  logic [NL-1:0]    pend_s;
  logic [7:0]       pend8_s;
  logic [2:0]       prio_id_s;
  logic             int_req_s;
  logic             take_s;
  logic             status_we_s, cause_we_s, epc_we_s;
  logic             df_set_s;
  logic [XLEN-1:0]  status_rd_s, cause_rd_s;
  logic             unused_wdata_s;

`ifdef CP0_TIMER_EN
  logic [XLEN-1:0] count_q, count_d;
  logic [XLEN-1:0] compare_q, compare_d;
  logic            compare_we_s;
  logic            timer_hit_s;

  assign compare_we_s = cp0_we & (cp0_addr == CP0_COMPARE);
  assign timer_hit_s  = (count_q == compare_q);
`endif

  cp0_irq_sync #(
    .WIDTH  (N_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (irq_in),
    .q_o (irq_sync_s)
  );

  assign status_we_s = cp0_we & (cp0_addr == CP0_STATUS);
  assign cause_we_s  = cp0_we & (cp0_addr == CP0_CAUSE);
  assign epc_we_s    = cp0_we & (cp0_addr == CP0_EPC);

  // Only selected wdata bits land in registers; fold the rest into a sink.
  assign unused_wdata_s = ^cp0_wdata;

  // Pending-bit set/clear sources; a set on the same edge beats a clear.
  always_comb begin
    ip_set_s = '0;
    ip_set_s[N_IRQ-1:0] = irq_sync_s;
    ip_clr_s = cause_we_s ? cp0_wdata[IP_LSB +: NL] : '0;
`ifdef CP0_TIMER_EN
    ip_set_s[N_IRQ] = timer_hit_s;
    ip_clr_s[N_IRQ] = ip_clr_s[N_IRQ] | compare_we_s;
`endif
    ip_d = (ip_q & ~ip_clr_s) | ip_set_s;
  end

  // Request, priority and the combinational take decision.
  always_comb begin
    pend_s    = ip_q & im_q;
    pend8_s   = 8'd0;
    pend8_s[NL-1:0] = pend_s;
    prio_id_s = lowest_set_idx(pend8_s);
    int_req_s = ie_q & (|pend_s);
    // eret in the same window suppresses any take.
    take_s    = (state_q == RUN) & take_window & ~eret & (syscall | int_req_s);
    df_set_s  = (state_q == HANDLER) & take_window & syscall & ~eret;
  end

  // FSM next state plus register next values; eret > take > mtc0.
  always_comb begin
    if (eret) begin
      state_d = RUN;
    end else if (take_s) begin
      state_d = HANDLER;
    end else begin
      state_d = state_q;
    end

    if (eret) begin
      ie_d = 1'b1;
    end else if (take_s) begin
      ie_d = 1'b0;
    end else if (status_we_s) begin
      ie_d = cp0_wdata[IE_BIT];
    end else begin
      ie_d = ie_q;
    end

    im_d = status_we_s ? cp0_wdata[IP_LSB +: NL] : im_q;

    if (take_s) begin
      epc_d = epc_in;
    end else if (epc_we_s) begin
      epc_d = cp0_wdata;
    end else begin
      epc_d = epc_q;
    end

    if (take_s) begin
      exc_d = syscall ? EXC_SYS : EXC_INT;
    end else begin
      exc_d = exc_q;
    end

    if (df_set_s) begin
      df_d = 1'b1;
    end else if (cause_we_s && cp0_wdata[DF_BIT]) begin
      df_d = 1'b0;
    end else begin
      df_d = df_q;
    end
  end

`ifdef CP0_TIMER_EN
  // Free-running counter and compare register next values.
  always_comb begin
    count_d   = count_q + {{(XLEN-1){1'b0}}, 1'b1};
    compare_d = compare_we_s ? cp0_wdata : compare_q;
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '1;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end
`endif

  // FSM state and CP0 register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ie_q    <= 1'b0;
      im_q    <= '0;
      ip_q    <= '0;
      exc_q   <= 5'd0;
      df_q    <= 1'b0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      im_q    <= im_d;
      ip_q    <= ip_d;
      exc_q   <= exc_d;
      df_q    <= df_d;
      epc_q   <= epc_d;
    end
  end

  // mfc0 read mux over the pre-edge register values.
  always_comb begin
    status_rd_s = '0;
    status_rd_s[IE_BIT] = ie_q;
    status_rd_s[IP_LSB +: NL] = im_q;
    cause_rd_s = '0;
    cause_rd_s[6:2] = exc_q;
    cause_rd_s[IP_LSB +: NL] = ip_q;
    cause_rd_s[DF_BIT] = df_q;
    case (cp0_addr)
      CP0_STATUS:  cp0_rdata = status_rd_s;
      CP0_CAUSE:   cp0_rdata = cause_rd_s;
      CP0_EPC:     cp0_rdata = epc_q;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   cp0_rdata = count_q;
      CP0_COMPARE: cp0_rdata = compare_q;
`else
      CP0_COUNT,
      CP0_COMPARE: cp0_rdata = '0;
`endif
      default:     cp0_rdata = '0;
    endcase
  end

  assign take       = take_s;
  assign irq_id     = (take_s && !syscall) ? prio_id_s : 3'd0;
  assign vec_pc     = VEC_BASE;
  assign eret_pc    = epc_q;
  assign in_handler = (state_q == HANDLER);

endmodule
